// File: rtl/niveles_pkg.sv
// Shared state encodings, default parameter values and the level-to-state
// classification used by niveles_multicanal and canal_nivel.
package niveles_pkg;

  typedef enum logic [1:0] {
    SANO    = 2'd0,
    ALERTA  = 2'd1,
    CRITICO = 2'd2,
    MUERTO  = 2'd3
  } estado_t;

  localparam int N_CANALES_DEF       = 4;
  localparam int ANCHO_NIVEL_DEF     = 2;
  localparam int PERIODO_DEF         = 65;
  localparam int UMBRAL_ALERTA_DEF   = 2;
  localparam int PERIODOS_MUERTE_DEF = 3;

  // An empty channel dominates a low channel; otherwise everyone is healthy.
  function automatic estado_t clasificar(input logic hay_cero, input logic hay_bajo);
    if (hay_cero)      return CRITICO;
    else if (hay_bajo) return ALERTA;
    else               return SANO;
  endfunction

endpackage

// File: rtl/canal_nivel.sv
// One need channel: decay timer, saturating level and raise qualification.
// NIVELES_SUBE_FLANCO_EN selects edge-qualified raises; default is level-qualified.
module canal_nivel
  import niveles_pkg::*;
#(
  parameter int ANCHO_NIVEL   = ANCHO_NIVEL_DEF,
  parameter int NIVEL_INICIAL = 2**ANCHO_NIVEL - 1,
  parameter int PERIODO       = PERIODO_DEF
) (
  input  logic                   clk,
  input  logic                   B_reset,
  input  logic                   avanza,
  input  logic                   sube,
  output logic [ANCHO_NIVEL-1:0] nivel,
  output logic [ANCHO_NIVEL-1:0] nivel_sig
);

  localparam int                     ANCHO_TIMER = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam logic [ANCHO_TIMER-1:0] TIMER_FIN   = ANCHO_TIMER'(PERIODO - 1);
  localparam logic [ANCHO_NIVEL-1:0] NIVEL_MAX   = '1;
  localparam logic [ANCHO_NIVEL-1:0] NIVEL_RESET = ANCHO_NIVEL'(NIVEL_INICIAL);

  logic [ANCHO_TIMER-1:0] timer_q, timer_d;
  logic                   expira;
  logic                   sube_ok;

`ifdef NIVELES_SUBE_FLANCO_EN
  // Previous value resets to 1 so a request already high out of reset does not count.
  logic sube_prev;

  always_ff @(posedge clk) begin
    if (B_reset)     sube_prev <= 1'b1;
    else if (avanza) sube_prev <= sube;
  end

  assign sube_ok = avanza && sube && !sube_prev;
`else
  assign sube_ok = avanza && sube;
`endif

  assign expira = avanza && (timer_q == TIMER_FIN);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    timer_d   = timer_q;
    nivel_sig = nivel;
    if (expira)      timer_d = '0;
    else if (avanza) timer_d = timer_q + 1'b1;

    // A simultaneous decay and raise cancel out.
    if (expira && !sube_ok) begin
      if (nivel != '0) nivel_sig = nivel - 1'b1;
    end else if (sube_ok && !expira) begin
      if (nivel != NIVEL_MAX) nivel_sig = nivel + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (B_reset) begin
      timer_q <= '0;
      nivel   <= NIVEL_RESET;
    end else begin
      timer_q <= timer_d;
      nivel   <= nivel_sig;
    end
  end

endmodule

// File: rtl/niveles_multicanal.sv
// Multi-channel need levels with a shared health FSM and death counter.
// Optional build macro NIVELES_SUBE_FLANCO_EN makes raises edge-qualified.
module niveles_multicanal
  import niveles_pkg::*;
#(
  parameter int N_CANALES       = N_CANALES_DEF,
  parameter int ANCHO_NIVEL     = ANCHO_NIVEL_DEF,
  parameter int NIVEL_INICIAL   = 2**ANCHO_NIVEL - 1,
  parameter int PERIODO         = PERIODO_DEF,
  parameter int UMBRAL_ALERTA   = UMBRAL_ALERTA_DEF,
  parameter int PERIODOS_MUERTE = PERIODOS_MUERTE_DEF
) (
  input  logic                             clk,
  input  logic                             B_reset,
  input  logic                             activo,
  input  logic [N_CANALES-1:0]             sube,
  output logic [N_CANALES*ANCHO_NIVEL-1:0] niveles,
  output logic [1:0]                       estado,
  output logic                             alerta,
  output logic                             muerto
);

  localparam int                      LIMITE_MUERTE  = PERIODO * PERIODOS_MUERTE;
  localparam int                      ANCHO_MUERTE   = $clog2(LIMITE_MUERTE + 1);
  localparam logic [ANCHO_MUERTE-1:0] ULTIMO_CICLO   = ANCHO_MUERTE'(LIMITE_MUERTE - 1);
  localparam estado_t                 ESTADO_INICIAL =
    clasificar(NIVEL_INICIAL == 0, NIVEL_INICIAL < UMBRAL_ALERTA);

  estado_t                         estado_q, estado_d;
  logic [ANCHO_MUERTE-1:0]         cuenta_q, cuenta_d;
  logic                            alerta_q, alerta_d;
  logic                            muerto_q;
  logic [N_CANALES*ANCHO_NIVEL-1:0] niveles_sig;
  logic                            avanza;
  logic                            hay_cero, hay_bajo;

  // Death freezes everything exactly like a deasserted activo.
  assign avanza = activo && (estado_q != MUERTO);

  for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
    canal_nivel #(
      .ANCHO_NIVEL  (ANCHO_NIVEL),
      .NIVEL_INICIAL(NIVEL_INICIAL),
      .PERIODO      (PERIODO)
    ) u_canal (
      .clk      (clk),
      .B_reset  (B_reset),
      .avanza   (avanza),
      .sube     (sube[i]),
      .nivel    (niveles[i*ANCHO_NIVEL +: ANCHO_NIVEL]),
      .nivel_sig(niveles_sig[i*ANCHO_NIVEL +: ANCHO_NIVEL])
    );
  end

  // Classification looks at next-cycle levels so state and levels move together.
  always_comb begin
    hay_cero = 1'b0;
    hay_bajo = 1'b0;
    for (int i = 0; i < N_CANALES; i++) begin
      if (niveles_sig[i*ANCHO_NIVEL +: ANCHO_NIVEL] == '0) hay_cero = 1'b1;
      if (int'(niveles_sig[i*ANCHO_NIVEL +: ANCHO_NIVEL]) < UMBRAL_ALERTA) hay_bajo = 1'b1;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cuenta_d = cuenta_q;
    if (avanza) begin
      if (estado_q == CRITICO && cuenta_q == ULTIMO_CICLO) begin
        estado_d = MUERTO;
        cuenta_d = cuenta_q + 1'b1;
      end else begin
        estado_d = clasificar(hay_cero, hay_bajo);
        if (estado_q == CRITICO && estado_d == CRITICO) cuenta_d = cuenta_q + 1'b1;
        else                                            cuenta_d = '0;
      end
    end
    alerta_d = hay_bajo && (estado_d != MUERTO);
  end

  always_ff @(posedge clk) begin
    if (B_reset) begin
      estado_q <= ESTADO_INICIAL;
      cuenta_q <= '0;
      alerta_q <= (NIVEL_INICIAL < UMBRAL_ALERTA);
      muerto_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cuenta_q <= cuenta_d;
      alerta_q <= alerta_d;
      muerto_q <= (estado_d == MUERTO);
    end
  end

  assign estado = estado_q;
  assign alerta = alerta_q;
  assign muerto = muerto_q;

endmodule

// File: tb/tb_niveles_multicanal.sv
// Self-checking bench for niveles_multicanal: directed scenarios plus a random
// run, all compared against an integer-arithmetic model of the channel rules.
module tb_niveles_multicanal;

  localparam int N  = 2;
  localparam int A  = 2;
  localparam int P  = 4;
  localparam int U  = 2;
  localparam int PM = 2;
  localparam int NMAX = 3;

  logic           clk = 1'b0;
  logic           B_reset = 1'b1;
  logic           activo = 1'b0;
  logic [N-1:0]   sube = '0;
  logic [N*A-1:0] niveles;
  logic [1:0]     estado;
  logic           alerta;
  logic           muerto;

  int comparaciones = 0;
  int fallos = 0;

  niveles_multicanal #(
    .N_CANALES(N), .ANCHO_NIVEL(A), .NIVEL_INICIAL(NMAX), .PERIODO(P),
    .UMBRAL_ALERTA(U), .PERIODOS_MUERTE(PM)
  ) dut (
    .clk(clk), .B_reset(B_reset), .activo(activo), .sube(sube),
    .niveles(niveles), .estado(estado), .alerta(alerta), .muerto(muerto)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers, one entry per channel.
  int lvl[N];
  int tmr[N];
  bit prv[N];
  int est;
  int critico_ciclos;

  function automatic int clasifica();
    bit cero = 0, bajo = 0;
    for (int i = 0; i < N; i++) begin
      if (lvl[i] == 0) cero = 1;
      if (lvl[i] < U)  bajo = 1;
    end
    return cero ? 2 : (bajo ? 1 : 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      lvl[i] = NMAX; tmr[i] = 0; prv[i] = 1;
    end
    est = clasifica();
    critico_ciclos = 0;
  endtask

  task automatic model_step(input bit a, input logic [N-1:0] s);
    int nuevo;
    if (!a || est == 3) return;
    for (int i = 0; i < N; i++) begin
      bit fin = (tmr[i] == P - 1);
      bit up;
`ifdef NIVELES_SUBE_FLANCO_EN
      up = s[i] && !prv[i];
`else
      up = s[i];
`endif
      prv[i] = s[i];
      tmr[i] = fin ? 0 : tmr[i] + 1;
      if (fin && !up && lvl[i] > 0)         lvl[i]--;
      else if (up && !fin && lvl[i] < NMAX) lvl[i]++;
    end
    if (est == 2 && critico_ciclos + 1 == P * PM) begin
      est = 3;
    end else begin
      nuevo = clasifica();
      critico_ciclos = (est == 2 && nuevo == 2) ? critico_ciclos + 1 : 0;
      est = nuevo;
    end
  endtask

  function automatic logic [7:0] esperado();
    bit bajo = 0;
    for (int i = 0; i < N; i++) if (lvl[i] < U) bajo = 1;
    return {2'(lvl[1]), 2'(lvl[0]), 2'(est), bajo && est != 3, est == 3};
  endfunction

  task automatic paso(input bit rst, input bit a, input logic [N-1:0] s);
    B_reset = rst; activo = a; sube = s;
    @(posedge clk);
    if (rst) model_reset(); else model_step(a, s);
    #1;
  endtask

  task automatic test_reset();
    paso(1, 0, '0);
    comparaciones++;
    if ({niveles, estado, alerta, muerto} !== 8'b1111_00_0_0) begin
      fallos++;
      $display("FAIL reset: got %b want %b", {niveles, estado, alerta, muerto}, 8'b1111_00_0_0);
    end
  endtask

  task automatic test_decaimiento();
    paso(1, 0, '0);
    for (int c = 1; c <= 12; c++) begin
      paso(0, 1, '0);
      comparaciones++;
      if ({niveles, estado, alerta, muerto} !== esperado()) begin
        fallos++;
        $display("FAIL decay c%0d: got %b want %b", c, {niveles, estado, alerta, muerto}, esperado());
      end
    end
    comparaciones++;
    if ({niveles, estado, alerta} !== 7'b0000_10_1) begin
      fallos++;
      $display("FAIL decay_end: got %b want %b", {niveles, estado, alerta}, 7'b0000_10_1);
    end
  endtask

  task automatic test_expira_y_sube();
    paso(1, 0, '0);
    for (int c = 1; c <= 11; c++) paso(0, 1, '0);
    paso(0, 1, 2'b01);
    comparaciones++;
    if (niveles !== 4'b00_01) begin
      fallos++;
      $display("FAIL expiry_raise: got %b want %b", niveles, 4'b00_01);
    end
    for (int c = 1; c <= 4; c++) begin
      paso(0, 1, '0);
      comparaciones++;
      if ({niveles, estado, alerta, muerto} !== esperado()) begin
        fallos++;
        $display("FAIL expiry_restart c%0d: got %b want %b", c, {niveles, estado, alerta, muerto}, esperado());
      end
    end
  endtask

  task automatic test_sube_sostenido();
    logic [1:0] fin0;
`ifdef NIVELES_SUBE_FLANCO_EN
    fin0 = 2'd1;
`else
    fin0 = 2'd3;
`endif
    paso(1, 0, '0);
    for (int c = 1; c <= 8; c++) paso(0, 1, '0);
    for (int c = 1; c <= 5; c++) begin
      paso(0, 1, 2'b01);
      comparaciones++;
      if ({niveles, estado, alerta, muerto} !== esperado()) begin
        fallos++;
        $display("FAIL hold_raise c%0d: got %b want %b", c, {niveles, estado, alerta, muerto}, esperado());
      end
    end
    comparaciones++;
    if (niveles !== {2'd0, fin0}) begin
      fallos++;
      $display("FAIL hold_raise_end: got %b want %b", niveles, {2'd0, fin0});
    end
  endtask

  task automatic test_muerte();
    paso(1, 0, '0);
    for (int c = 1; c <= 12; c++) paso(0, 1, '0);
    for (int c = 1; c <= 8; c++) begin
      paso(0, 1, '0);
      comparaciones++;
      if ({niveles, estado, alerta, muerto} !== esperado()) begin
        fallos++;
        $display("FAIL death c%0d: got %b want %b", c, {niveles, estado, alerta, muerto}, esperado());
      end
    end
    comparaciones++;
    if ({estado, muerto} !== 3'b11_1) begin
      fallos++;
      $display("FAIL death_enter: got %b want %b", {estado, muerto}, 3'b11_1);
    end
    for (int c = 1; c <= 6; c++) paso(0, 1, 2'b11);
    comparaciones++;
    if ({niveles, estado, alerta, muerto} !== 8'b0000_11_0_1) begin
      fallos++;
      $display("FAIL death_absorb: got %b want %b", {niveles, estado, alerta, muerto}, 8'b0000_11_0_1);
    end
    paso(1, 1, 2'b11);
    comparaciones++;
    if ({niveles, estado, alerta, muerto} !== 8'b1111_00_0_0) begin
      fallos++;
      $display("FAIL death_reset: got %b want %b", {niveles, estado, alerta, muerto}, 8'b1111_00_0_0);
    end
  endtask

  task automatic test_pausa();
    paso(1, 0, '0);
    for (int c = 1; c <= 6; c++) paso(0, 1, '0);
    for (int c = 1; c <= 10; c++) paso(0, 0, 2'($urandom_range(0, 3)));
    comparaciones++;
    if ({niveles, estado, alerta, muerto} !== 8'b1010_00_0_0) begin
      fallos++;
      $display("FAIL pause_hold: got %b want %b", {niveles, estado, alerta, muerto}, 8'b1010_00_0_0);
    end
    paso(0, 1, '0);
    comparaciones++;
    if (niveles !== 4'b1010) begin
      fallos++;
      $display("FAIL pause_resume1: got %b want %b", niveles, 4'b1010);
    end
    paso(0, 1, '0);
    comparaciones++;
    if ({niveles, estado, alerta} !== 7'b0101_01_1) begin
      fallos++;
      $display("FAIL pause_resume2: got %b want %b", {niveles, estado, alerta}, 7'b0101_01_1);
    end
  endtask

  task automatic test_aleatorio();
    logic [N-1:0] s;
    bit a, r;
    paso(1, 0, '0);
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 79) == 0);
      a = ($urandom_range(0, 7) != 0);
      s = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 3)) : '0;
      paso(r, a, s);
      comparaciones++;
      if ({niveles, estado, alerta, muerto} !== esperado()) begin
        fallos++;
        $display("FAIL random c%0d: got %b want %b", c, {niveles, estado, alerta, muerto}, esperado());
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_decaimiento();
    test_expira_y_sube();
    test_sube_sostenido();
    test_muerte();
    test_pausa();
    test_aleatorio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparaciones, fallos);
    $finish;
  end

endmodule

// File: doc/niveles_multicanal.md
NIVELES_MULTICANAL -- requirements
Module: niveles_multicanal

Interface
REQ-001 Parameter N_CANALES, default 4, number of independent need channels (1..8).
REQ-002 Parameter ANCHO_NIVEL, default 2, bits per level; NIVEL_MAX = 2**ANCHO_NIVEL-1.
REQ-003 Parameter NIVEL_INICIAL, default NIVEL_MAX, level loaded at reset.
REQ-004 Parameter PERIODO, default 65, activo cycles per decay step per channel (>=2).
REQ-005 Parameter UMBRAL_ALERTA, default 2, levels strictly below this raise alerta.
REQ-006 Parameter PERIODOS_MUERTE, default 3, decay periods spent in CRITICO before MUERTO.
REQ-007 clk  input  1  single clock, all logic on rising edge.
REQ-008 B_reset  input  1  synchronous, active-high reset.
REQ-009 activo  input  1  enable; low freezes all state.
REQ-010 sube  input  N_CANALES  per-channel raise request, bit i for channel i.
REQ-011 niveles  output  N_CANALES*ANCHO_NIVEL  packed levels, channel i at bits [i*ANCHO_NIVEL +: ANCHO_NIVEL].
REQ-012 estado  output  2  SANO=0, ALERTA=1, CRITICO=2, MUERTO=3.
REQ-013 alerta  output  1  high when any level < UMBRAL_ALERTA and estado != MUERTO.
REQ-014 muerto  output  1  high iff estado == MUERTO.

Function
REQ-015 All outputs SHALL be registered; any level/state change appears one clk after the qualifying event.
REQ-016 Each channel SHALL have a timer counting 0..PERIODO-1 on activo cycles; expiry = timer at PERIODO-1 with activo high.
REQ-017 On expiry the timer SHALL return to 0 and the level SHALL decrement by 1, saturating at 0.
REQ-018 A qualifying raise SHALL increment the level by 1, saturating at NIVEL_MAX; the timer is unaffected.
REQ-019 Expiry and raise on the same channel in the same cycle SHALL leave the level unchanged and reset the timer.
REQ-020 Channels SHALL be fully independent; simultaneous events on different channels all take effect.
REQ-021 With activo low, timers, levels, FSM and death counter SHALL hold and sube SHALL be ignored.
REQ-022 FSM next state (evaluated on the updated levels): any level 0 -> CRITICO; else any level < UMBRAL_ALERTA -> ALERTA; else SANO.
REQ-023 In CRITICO a death counter SHALL count activo cycles; reaching PERIODO*PERIODOS_MUERTE SHALL enter MUERTO next cycle.
REQ-024 Leaving CRITICO before MUERTO SHALL clear the death counter to 0.
REQ-025 MUERTO SHALL be absorbing: levels, timers frozen, sube ignored; only B_reset exits.
REQ-026 Counter widths SHALL be $clog2-sized to hold their maximum value without wrap.

Reset
REQ-027 B_reset high at a clk edge SHALL set every level to NIVEL_INICIAL, timers and death counter to 0, estado to the state implied by NIVEL_INICIAL per REQ-022, muerto to 0.
REQ-028 Reset SHALL override all other inputs, including mid-period and in MUERTO.

Configuration
REQ-029 Macro NIVELES_SUBE_FLANCO_EN defined: a raise qualifies only on a 0->1 transition of sube[i] (one registered previous-value bit per channel, reset to 1).
REQ-030 Macro undefined: a raise qualifies on every activo cycle in which sube[i] is high (level-sensitive).

Structure
REQ-031 Package niveles_pkg SHALL hold the estado encodings and default parameter constants.
REQ-032 Sub-module canal_nivel SHALL implement one channel (timer, level, optional edge detector), instantiated N_CANALES times via generate; FSM and death counter stay in the top.

Verification (N_CANALES=2, ANCHO_NIVEL=2, PERIODO=4, UMBRAL_ALERTA=2, PERIODOS_MUERTE=2, macro defined unless noted)
REQ-033 Reset, activo=1, sube=0 for 12 cycles -> niveles go 3,3 -> 2,2 -> 1,1 -> 0,0 at cycles 4, 8, 12; estado SANO->SANO->ALERTA->CRITICO, alerta high from cycle 8.
REQ-034 Channel 0 at 1, sube[0] pulse on its expiry cycle -> level stays 1, timer restarts at 0; channel 1 decays normally.
REQ-035 Hold sube[0]=1 for 5 cycles with macro defined -> +1 once; macro undefined -> +1 per cycle, saturating at 3.
REQ-036 Stay in CRITICO 8 activo cycles -> estado=3, muerto=1; later sube=2'b11 -> no change; B_reset -> niveles 3,3, estado SANO.
REQ-037 activo low for 10 cycles mid-period -> niveles, estado, timers unchanged; resume -> next decay exactly after remaining period cycles.
